program_loader: RTL and testbench

- Boot-time loader upstream of the CPU's instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words into the instruction memory write port and verifies an XOR checksum.
- Holds the CPU in reset until the load completes successfully.

---
 rtl/program_loader.sv | 153 +++++++++++++++
 tb/tb_program_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot-time program loader: receives a byte stream (16-bit word count,
// little-endian 32-bit words, XOR checksum), writes each word into the
// instruction memory write port and releases the CPU reset only once the
// checksum has matched.
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready;
// in_ready depends on the FSM state alone, never on in_valid, and in_valid
// may drop for any number of cycles between bytes.
//
// Observation point: state_q holds the current FSM state (state_e).
module program_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WORDS  = 2 ** (ADDR_WIDTH - 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [15:0]           words_loaded,
  output logic                  cpu_reset,
  output logic                  load_done,
  output logic                  load_err
);

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_e;

  // One extra bit so a count of 0xFFFF compares correctly against the limit.
  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;          // header word count N
  logic [1:0]            byte_cnt_q, byte_cnt_d; // lane of the next data byte
  logic [7:0]            xor_q, xor_d;          // running XOR of all bytes so far
  logic [23:0]           asm_q, asm_d;          // lanes 0..2; lane 3 comes straight from in_data
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [15:0]           wl_q, wl_d;            // words written, doubles as word index
  logic                  accept;

  assign accept = in_valid && in_ready;

  // State register and datapath registers; reset wins over a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_HDR0;
      cnt_q      <= '0;
      byte_cnt_q <= '0;
      xor_q      <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wl_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      byte_cnt_q <= byte_cnt_d;
      xor_q      <= xor_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wl_q       <= wl_d;
    end
  end

  // Next-state logic: header parse, word assembly, checksum compare.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    byte_cnt_d = byte_cnt_q;
    xor_d      = xor_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wl_d       = wl_q;
    case (state_q)
      S_HDR0: begin
        if (accept) begin
          cnt_d   = {8'h00, in_data};
          xor_d   = xor_q ^ in_data;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          cnt_d = {in_data, cnt_q[7:0]};
          xor_d = xor_q ^ in_data;
          if ({1'b0, in_data, cnt_q[7:0]} > MAX_N) begin
            state_d = S_ERROR;
          end else if ({in_data, cnt_q[7:0]} == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d      = xor_q ^ in_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              // Fourth byte completes the word: launch the one-cycle write.
              we_d    = 1'b1;
              addr_d  = {wl_q[ADDR_WIDTH-3:0], 2'b00};
              wdata_d = {in_data, asm_q};
              wl_d    = wl_q + 16'd1;
              if (wl_q == cnt_q - 16'd1) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERROR;
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // Status outputs decoded from the registered state only.
  always_comb begin
    in_ready  = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                (state_q == S_DATA) || (state_q == S_CSUM);
    load_done = (state_q == S_DONE);
    load_err  = (state_q == S_ERROR);
    cpu_reset = (state_q != S_DONE);
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed streams plus random streams, with a
// stream-level reference model filling an expected-write queue that a
// separate monitor drains on every imem_we pulse.
module tb_program_loader;

  localparam int AW        = 12;
  localparam int MAX_WORDS = 2 ** (AW - 2);

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [15:0]   words_loaded;
  logic          cpu_reset;
  logic          load_done;
  logic          load_err;

  int checks = 0;
  int errors = 0;

  // Expected write entry: {words_loaded after write, addr, data}.
  logic [59:0] exp_q[$];
  logic [7:0]  stim_q[$];
  int          exp_words;
  int          exp_status; // 0 still loading, 1 done, 2 error

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .words_loaded (words_loaded),
    .cpu_reset    (cpu_reset),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_words_loaded", 32'(words_loaded), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_done", 32'(load_done), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_pending_writes", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- reference model ----------------
  // Interprets stim_q as a byte stream: header count, words, checksum.
  function automatic void model();
    int n;
    int sz;
    logic [7:0] x;
    sz         = stim_q.size();
    exp_words  = 0;
    exp_status = 0;
    if (sz < 2) return;
    n = int'({stim_q[1], stim_q[0]});
    if (n > MAX_WORDS) begin
      exp_status = 2;
      return;
    end
    for (int w = 0; w < n && (2 + 4 * w + 3) < sz; w++) begin
      exp_q.push_back({16'(w + 1), AW'(w * 4),
                       stim_q[2 + 4 * w + 3], stim_q[2 + 4 * w + 2],
                       stim_q[2 + 4 * w + 1], stim_q[2 + 4 * w]});
      exp_words = w + 1;
    end
    if (sz >= 4 * n + 3) begin
      x = 8'h00;
      for (int i = 0; i < 4 * n + 2; i++) x = x ^ stim_q[i];
      exp_status = (stim_q[4 * n + 2] == x) ? 1 : 2;
    end
  endfunction

  // ---------------- driver ----------------
  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap_lo, input int gap_hi);
    int waits;
    @(negedge clk);
    in_valid = 1'b0;
    repeat ($urandom_range(gap_hi, gap_lo)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waits    = 0;
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual=in_ready_low required=accept byte %0h", b);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
  endtask

  task automatic send_stream(input int gap_lo, input int gap_hi);
    foreach (stim_q[i]) send_byte(stim_q[i], gap_lo, gap_hi);
  endtask

  task automatic check_final(input string tag);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_load_done"}, 32'(load_done), 32'(exp_status == 1));
    check({tag, "_load_err"}, 32'(load_err), 32'(exp_status == 2));
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_status != 1));
    check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_status == 0));
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'(exp_words));
    check({tag, "_missing_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [59:0] e;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=addr %0h data %0h required=no write",
                 imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e[43:32]));
        check("write_data", imem_wdata, e[31:0]);
        check("write_words_loaded", 32'(words_loaded), 32'(e[59:44]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] x;
    int n;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();

    // 1: nominal two-word load, in_valid held high
    stim_q = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h01, 8'h20, 8'h20, 8'h10, 8'h22, 8'h00, 8'h34};
    model();
    send_stream(0, 0);
    check_final("s1");

    // 2: same stream with 1-3 idle cycles between bytes
    do_reset();
    model();
    send_stream(1, 3);
    check_final("s2");

    // 3: bad checksum, then extra valid pulses must be ignored
    do_reset();
    stim_q[10] = 8'h35;
    model();
    send_stream(0, 0);
    check_final("s3");
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(1, 0));
      in_data  = 8'($urandom);
    end
    check_final("s3_after");

    // 4: word count above the limit
    do_reset();
    stim_q = '{8'h01, 8'h04};
    model();
    send_stream(0, 0);
    check_final("s4");

    // 5: empty program
    do_reset();
    stim_q = '{8'h00, 8'h00, 8'h00};
    model();
    send_stream(0, 0);
    check_final("s5");

    // 6: reset after the 3rd byte of word 1, then full replay
    do_reset();
    stim_q = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h01, 8'h20, 8'h20, 8'h10, 8'h22};
    model();
    send_stream(0, 0);
    do_reset();
    stim_q = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h01, 8'h20, 8'h20, 8'h10, 8'h22, 8'h00, 8'h34};
    model();
    send_stream(0, 0);
    check_final("s6");

    // random streams, some with a corrupted checksum
    for (int it = 0; it < 8; it++) begin
      do_reset();
      n = $urandom_range(6, 0);
      stim_q = {};
      stim_q.push_back(8'(n));
      stim_q.push_back(8'h00);
      for (int i = 0; i < 4 * n; i++) stim_q.push_back(8'($urandom));
      x = 8'h00;
      foreach (stim_q[i]) x = x ^ stim_q[i];
      if ($urandom_range(3, 0) == 0) x = x ^ 8'($urandom_range(255, 1));
      stim_q.push_back(x);
      model();
      send_stream(0, 2);
      check_final("rand");
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
